// File: rtl/dmem_responder_if.sv
// Request/response bundle between the load/store control unit and dmem_responder.
// Master drives the request (mfa, rw, size, sign, addr, data_in); slave returns data_out, mfc, misalign.
// Request is a level held by the master until it sees mfc or misalign.
interface dmem_responder_if #(
  parameter int ADDR_W = 9
) ();
  logic              mfa;
  logic              rw;
  logic [1:0]        size;
  logic              sign;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              mfc;
  logic              misalign;

  modport master (
    output mfa, rw, size, sign, addr, data_in,
    input  data_out, mfc, misalign
  );

  modport slave (
    input  mfa, rw, size, sign, addr, data_in,
    output data_out, mfc, misalign
  );
endinterface

// File: rtl/dmem_responder.sv
// Big-endian byte/halfword/word data memory responder with sign/zero-extended loads.
// Latency: mfc/misalign at edge k+WAIT_CYCLES+1 with DMEM_WAIT_EN defined, else k+1.
// Backpressure: mfa is a held level; mfc/misalign stay up until mfa drops, dropping mfa early aborts.
module dmem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Request snapshot taken on the accepting edge; later input changes are ignored.
  typedef struct packed {
    logic              rw;
    logic [1:0]        size;
    logic              sign;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdat;
  } req_t;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  logic [7:0]        mem [0:(2**ADDR_W)-1];
  state_t            state_q;
  state_t            state_d;
  req_t              req_q;
  logic [31:0]       dout_q;
  logic              cnt_zero;
  logic              accept;
  logic              access;
  logic              misal;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       ld_dat;

  assign accept = (state_q == ST_IDLE) && bus.mfa;
  // The access edge: still requested, wait count exhausted, and not overridden by reset.
  assign access = (state_q == ST_WAIT) && bus.mfa && cnt_zero && reset_n;

  assign misal = (req_q.size == 2'b11)
              || ((req_q.size == 2'b01) && req_q.addr[0])
              || ((req_q.size == 2'b10) && (req_q.addr[1:0] != 2'b00));

  assign wr_en = access && !req_q.rw && !misal;
  assign rd_en = access &&  req_q.rw && !misal;

  // Legal halfword/word accesses are aligned, so these offsets never wrap within an access.
  assign a0 = req_q.addr;
  assign a1 = req_q.addr + ADDR_W'(1);
  assign a2 = req_q.addr + ADDR_W'(2);
  assign a3 = req_q.addr + ADDR_W'(3);

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

`ifdef DMEM_WAIT_EN
  logic [3:0] cnt_q;

  // Wait-state counter: loaded on accept, counts down while the request is held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= 4'(WAIT_CYCLES);
    end else if ((state_q == ST_WAIT) && bus.mfa && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign cnt_zero = (cnt_q == 4'd0);
`else
  assign cnt_zero = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept, wait/abort, then hold the completion until mfa drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.mfa) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!bus.mfa) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = misal ? ST_ERR : ST_DONE;
        end
      end
      ST_DONE: if (!bus.mfa) state_d = ST_IDLE;
      ST_ERR:  if (!bus.mfa) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; load data comes from its own register.
  always_comb begin
    bus.mfc      = (state_q == ST_DONE);
    bus.misalign = (state_q == ST_ERR);
    bus.data_out = dout_q;
  end

  // Capture the request fields on the accepting edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q <= '0;
    end else if (accept) begin
      req_q <= '{rw: bus.rw, size: bus.size, sign: bus.sign,
                 addr: bus.addr, wdat: bus.data_in};
    end
  end

  // Load result formatting: big-endian, extension only when sign is set.
  always_comb begin
    ld_dat = 32'd0;
    case (req_q.size)
      2'b00:   ld_dat = {{24{req_q.sign & b0[7]}}, b0};
      2'b01:   ld_dat = {{16{req_q.sign & b0[7]}}, b0, b1};
      default: ld_dat = {b0, b1, b2, b3};
    endcase
  end

  // Load data register: only successful loads update it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_q <= 32'd0;
    end else if (rd_en) begin
      dout_q <= ld_dat;
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (req_q.size)
        2'b00: mem[a0] <= req_q.wdat[7:0];
        2'b01: begin
          mem[a0] <= req_q.wdat[15:8];
          mem[a1] <= req_q.wdat[7:0];
        end
        default: begin
          mem[a0] <= req_q.wdat[31:24];
          mem[a1] <= req_q.wdat[23:16];
          mem[a2] <= req_q.wdat[15:8];
          mem[a3] <= req_q.wdat[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed big-endian/extension/error cases,
// wait-state latency and hold behaviour, abort and reset-on-access, then random aligned traffic
// against a byte-array reference model with expected results queued per request.
module tb_dmem_responder;

  localparam int ADDR_W = 9;
  localparam int WAITC  = 3;
`ifdef DMEM_WAIT_EN
  localparam int EXP_WAIT = WAITC;
`else
  localparam int EXP_WAIT = 0;
`endif

  typedef struct {
    logic        err;
    logic [31:0] dout;
  } exp_t;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;
  exp_t sb [$];
  logic [7:0]  ref_mem [0:(2**ADDR_W)-1];
  logic [31:0] last_dout;

  dmem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAITC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [8:0] a);
    logic [7:0] c0, c1, c2, c3;
    c0 = ref_mem[a];
    c1 = ref_mem[9'(a + 9'd1)];
    c2 = ref_mem[9'(a + 9'd2)];
    c3 = ref_mem[9'(a + 9'd3)];
    if (sz == 2'b00) return {(sg && c0[7]) ? 24'hFFFFFF : 24'h0, c0};
    if (sz == 2'b01) return {(sg && c0[7]) ? 16'hFFFF : 16'h0, c0, c1};
    return {c0, c1, c2, c3};
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [8:0] a, input logic [31:0] d);
    if (sz == 2'b00) begin
      ref_mem[a] = d[7:0];
    end else if (sz == 2'b01) begin
      ref_mem[a] = d[15:8];
      ref_mem[9'(a + 9'd1)] = d[7:0];
    end else begin
      ref_mem[a] = d[31:24];
      ref_mem[9'(a + 9'd1)] = d[23:16];
      ref_mem[9'(a + 9'd2)] = d[15:8];
      ref_mem[9'(a + 9'd3)] = d[7:0];
    end
  endtask

  // One full handshake; inputs are scrambled right after the accepting edge.
  task automatic run_req(input logic rw_i, input logic [1:0] sz, input logic sg,
                         input logic [8:0] a, input logic [31:0] d,
                         input logic [31:0] exp_load, input logic exp_err,
                         input int extra_hold, input string tag);
    exp_t e;
    exp_t got_e;
    int   cyc;
    bit   done;
    e.err  = exp_err;
    e.dout = (rw_i && !exp_err) ? exp_load : last_dout;
    sb.push_back(e);
    last_dout = e.dout;
    if (!rw_i && !exp_err) model_store(sz, a, d);

    @(negedge clk);
    bus.rw = rw_i; bus.size = sz; bus.sign = sg; bus.addr = a; bus.data_in = d;
    bus.mfa = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        bus.rw = 1'($urandom); bus.size = 2'($urandom); bus.sign = 1'($urandom);
        bus.addr = 9'($urandom); bus.data_in = $urandom;
      end
      if (bus.mfc || bus.misalign) done = 1'b1;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(EXP_WAIT + 2));
    got_e = sb.pop_front();
    chk({tag, " misalign"}, 32'(bus.misalign), 32'(got_e.err));
    chk({tag, " mfc"}, 32'(bus.mfc), 32'(!got_e.err));
    chk({tag, " data_out"}, bus.data_out, got_e.dout);
    for (int i = 0; i < extra_hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " held"}, 32'(bus.mfc | bus.misalign), 32'd1);
    end
    @(negedge clk);
    bus.mfa = 1'b0;
    @(posedge clk); #1;
    chk({tag, " release"}, 32'({bus.mfc, bus.misalign}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rnd_rw;
    logic       rnd_sg;
    logic [1:0] rnd_sz;
    logic [8:0] rnd_a;
    logic [31:0] rnd_d;
    tests_run = 0;
    tests_failed = 0;
    last_dout = 32'd0;
    reset_n = 1'b0;
    bus.mfa = 1'b0; bus.rw = 1'b0; bus.size = 2'b00; bus.sign = 1'b0;
    bus.addr = '0; bus.data_in = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset data_out", bus.data_out, 32'd0);
    chk("reset mfc", 32'(bus.mfc), 32'd0);
    chk("reset misalign", 32'(bus.misalign), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Big-endian placement and extension.
    run_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h8123_45F6, 32'h0, 1'b0, 0, "st_w 010");
    run_req(1'b1, 2'b00, 1'b0, 9'h010, 32'h0, 32'h0000_0081, 1'b0, 0, "ld_ub 010");
    run_req(1'b1, 2'b00, 1'b1, 9'h010, 32'h0, 32'hFFFF_FF81, 1'b0, 0, "ld_sb 010");
    run_req(1'b1, 2'b01, 1'b1, 9'h012, 32'h0, 32'h0000_45F6, 1'b0, 0, "ld_sh 012");
    run_req(1'b0, 2'b00, 1'b0, 9'h011, 32'hFFFF_FFAA, 32'h0, 1'b0, 0, "st_b 011");
    run_req(1'b1, 2'b10, 1'b1, 9'h010, 32'h0, 32'h81AA_45F6, 1'b0, 2, "ld_w 010 hold");

    // Error cases leave memory and data_out alone.
    run_req(1'b1, 2'b01, 1'b0, 9'h013, 32'h0, 32'h0, 1'b1, 0, "ld_h 013 err");
    run_req(1'b0, 2'b10, 1'b0, 9'h012, 32'h1111_1111, 32'h0, 1'b1, 0, "st_w 012 err");
    run_req(1'b1, 2'b11, 1'b0, 9'h010, 32'h0, 32'h0, 1'b1, 1, "size11 err");
    run_req(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 32'h81AA_45F6, 1'b0, 0, "ld_w 010 after err");

    // Halfword store and negative extension.
    run_req(1'b0, 2'b10, 1'b0, 9'h020, 32'hFEDC_BA98, 32'h0, 1'b0, 0, "st_w 020");
    run_req(1'b0, 2'b01, 1'b0, 9'h022, 32'h1234_8001, 32'h0, 1'b0, 0, "st_h 022");
    run_req(1'b1, 2'b10, 1'b1, 9'h020, 32'h0, 32'hFEDC_8001, 1'b0, 0, "ld_w 020");
    run_req(1'b1, 2'b01, 1'b1, 9'h022, 32'h0, 32'hFFFF_8001, 1'b0, 0, "ld_sh 022");
    run_req(1'b1, 2'b01, 1'b0, 9'h020, 32'h0, 32'h0000_FEDC, 1'b0, 0, "ld_uh 020");
    run_req(1'b1, 2'b00, 1'b1, 9'h023, 32'h0, 32'h0000_0001, 1'b0, 0, "ld_sb 023");

    // Abort: mfa dropped during WAIT, no write may happen.
    @(negedge clk);
    bus.rw = 1'b0; bus.size = 2'b00; bus.sign = 1'b0; bus.addr = 9'h010; bus.data_in = 32'h55;
    bus.mfa = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mfa = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort no completion", 32'(bus.mfc | bus.misalign), 32'd0);
    end
    run_req(1'b1, 2'b00, 1'b0, 9'h010, 32'h0, 32'h0000_0081, 1'b0, 0, "ld after abort");

    // Reset on the access edge of a store: discarded, outputs back to reset values.
    @(negedge clk);
    bus.rw = 1'b0; bus.size = 2'b00; bus.sign = 1'b0; bus.addr = 9'h011; bus.data_in = 32'h66;
    bus.mfa = 1'b1;
    @(posedge clk);
    repeat (EXP_WAIT) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst access mfc", 32'(bus.mfc), 32'd0);
    chk("rst access misalign", 32'(bus.misalign), 32'd0);
    chk("rst access data_out", bus.data_out, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.mfa = 1'b0;
    last_dout = 32'd0;
    @(posedge clk); #1;
    chk("post rst idle", 32'(bus.mfc | bus.misalign), 32'd0);
    run_req(1'b1, 2'b00, 1'b0, 9'h011, 32'h0, 32'h0000_00AA, 1'b0, 0, "ld after rst store");

    // Random aligned traffic against the reference model.
    for (int i = 0; i < 4; i++) begin
      rnd_d = $urandom;
      run_req(1'b0, 2'b10, 1'b0, 9'(9'h100 + 9'(4 * i)), rnd_d, 32'h0, 1'b0, 0, "rnd init");
    end
    for (int i = 0; i < 20; i++) begin
      rnd_rw = 1'($urandom);
      rnd_sg = 1'($urandom);
      rnd_sz = 2'($urandom_range(0, 2));
      rnd_a  = 9'(9'h100 + 9'($urandom_range(0, 15)));
      if (rnd_sz == 2'b01) rnd_a[0] = 1'b0;
      if (rnd_sz == 2'b10) rnd_a[1:0] = 2'b00;
      rnd_d = $urandom;
      run_req(rnd_rw, rnd_sz, rnd_sg, rnd_a, rnd_d,
              rnd_rw ? model_load(rnd_sz, rnd_sg, rnd_a) : 32'h0, 1'b0, 0, "rnd op");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
